// File: rtl/pmem_ctrl_pkg.sv
// Shared definitions for the program-memory controller.
//   - state_e      : controller phase encoding (idle / boot-load / fetch)
//   - *_DEF        : default widths and reset PC used by pmem_ctrl
package pmem_ctrl_pkg;

  localparam int unsigned AW_DEF       = 8;
  localparam int unsigned IW_DEF       = 12;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/pmem_ctrl_pc_unit.sv
// Program counter for the fetch port.
//   clk, rst     : clock, async active-high reset (pc -> RESET_PC)
//   set_i        : reload RESET_PC (entering RUN); highest priority
//   jump_i       : load jmp_addr_i
//   adv_i        : increment, wrapping modulo 2**AW
//   jmp_addr_i   : redirect target
//   pc_o         : current pc
module pmem_ctrl_pc_unit #(
  parameter int unsigned    AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_i,
  input  logic          jump_i,
  input  logic          adv_i,
  input  logic [AW-1:0] jmp_addr_i,
  output logic [AW-1:0] pc_o
);

  logic [AW-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (set_i)       pc_d = RESET_PC;
    else if (jump_i) pc_d = jmp_addr_i;
    else if (adv_i)  pc_d = pc_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pmem_ctrl.sv
// Program-memory controller: boot-loads a program through the memory's
// LE/LA/LI write port, then fetches instructions into an instruction register.
//   clk, rst                    : clock, async active-high reset
//   start_load/start_run/stop_run : phase control pulses
//   ld_valid/ld_data/ld_last/ld_ready : load stream (ready only in LOAD)
//   pm_le/pm_la/pm_li           : registered memory write port
//   pm_e/pm_addr/pm_i           : fetch port (combinational memory read)
//   run_en/jmp_valid/jmp_addr   : fetch advance / redirect
//   ir/ir_pc/ir_valid           : instruction register for decode
//   load_done/load_count/err_ovf: load status
module pmem_ctrl
  import pmem_ctrl_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned IW       = IW_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_load,
  input  logic          start_run,
  input  logic          stop_run,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          pm_le,
  output logic [AW-1:0] pm_la,
  output logic [IW-1:0] pm_li,
  output logic          pm_e,
  output logic [AW-1:0] pm_addr,
  input  logic [IW-1:0] pm_i,
  input  logic          run_en,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_addr,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          err_ovf
);

  localparam logic [AW-1:0] ResetPc = RESET_PC[AW-1:0];
  localparam logic [AW:0]   CntMax  = {1'b1, {AW{1'b0}}};

  state_e state_d, state_q;

  logic [AW-1:0] wr_addr_d, wr_addr_q;
  logic [AW:0]   load_count_d, load_count_q;
  logic          err_ovf_d, err_ovf_q;
  logic          pm_le_d, pm_le_q;
  logic [AW-1:0] pm_la_d, pm_la_q;
  logic [IW-1:0] pm_li_d, pm_li_q;
  logic          load_done_d, load_done_q;
  logic [IW-1:0] ir_d, ir_q;
  logic [AW-1:0] ir_pc_d, ir_pc_q;
  logic          ir_valid_d, ir_valid_q;

  logic          accept, enter_load, enter_run, stay_run;
  logic [AW-1:0] pc;

  assign accept     = (state_q == ST_LOAD) && ld_valid;
  assign enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  assign enter_run  = (state_d == ST_RUN) && (state_q != ST_RUN);
  assign stay_run   = (state_d == ST_RUN) && (state_q == ST_RUN);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_load)     state_d = ST_LOAD;
        else if (start_run) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (accept && ld_last) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (start_load)    state_d = ST_LOAD;
        else if (stop_run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ld_ready = (state_q == ST_LOAD);
    pm_e     = (state_q == ST_RUN);
  end

  pmem_ctrl_pc_unit #(
    .AW       (AW),
    .RESET_PC (ResetPc)
  ) u_pc_unit (
    .clk        (clk),
    .rst        (rst),
    .set_i      (enter_run),
    .jump_i     (stay_run && jmp_valid),
    .adv_i      (stay_run && !jmp_valid && run_en),
    .jmp_addr_i (jmp_addr),
    .pc_o       (pc)
  );

  // Load datapath and instruction register
  always_comb begin
    wr_addr_d    = wr_addr_q;
    load_count_d = load_count_q;
    err_ovf_d    = err_ovf_q;
    pm_le_d      = 1'b0;
    pm_la_d      = pm_la_q;
    pm_li_d      = pm_li_q;
    load_done_d  = accept && ld_last;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;

    if (enter_load) begin
      wr_addr_d    = '0;
      load_count_d = '0;
      err_ovf_d    = 1'b0;
    end else if (accept) begin
      if (load_count_q == CntMax) begin
        // Memory already full: drop the word and flag it.
        err_ovf_d = 1'b1;
      end else begin
        pm_le_d      = 1'b1;
        pm_la_d      = wr_addr_q;
        pm_li_d      = ld_data;
        wr_addr_d    = wr_addr_q + AW'(1);
        load_count_d = load_count_q + (AW+1)'(1);
      end
    end

    if (stay_run) begin
      if (jmp_valid) begin
        // The word fetched at the old pc is flushed.
        ir_valid_d = 1'b0;
      end else if (run_en) begin
        ir_d       = pm_i;
        ir_pc_d    = pc;
        ir_valid_d = 1'b1;
      end
    end else begin
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q    <= '0;
      load_count_q <= '0;
      err_ovf_q    <= 1'b0;
      pm_le_q      <= 1'b0;
      pm_la_q      <= '0;
      pm_li_q      <= '0;
      load_done_q  <= 1'b0;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      load_count_q <= load_count_d;
      err_ovf_q    <= err_ovf_d;
      pm_le_q      <= pm_le_d;
      pm_la_q      <= pm_la_d;
      pm_li_q      <= pm_li_d;
      load_done_q  <= load_done_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
    end
  end

  assign pm_le      = pm_le_q;
  assign pm_la      = pm_la_q;
  assign pm_li      = pm_li_q;
  assign pm_addr    = pc;
  assign ir         = ir_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  assign load_done  = load_done_q;
  assign load_count = load_count_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_pmem_ctrl.sv
module tb_pmem_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load, start_run, stop_run;
  logic          ld_valid, ld_last, ld_ready;
  logic [IW-1:0] ld_data;
  logic          pm_le, pm_e;
  logic [AW-1:0] pm_la, pm_addr;
  logic [IW-1:0] pm_li, pm_i;
  logic          run_en, jmp_valid;
  logic [AW-1:0] jmp_addr;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid, load_done, err_ovf;
  logic [AW:0]   load_count;

  logic [IW-1:0] mem [2**AW];

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Behavioural program memory: registered write, combinational read.
  always @(posedge clk) if (pm_le) mem[pm_la] <= pm_li;
  assign pm_i = mem[pm_addr];

  pmem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .start_run  (start_run),
    .stop_run   (stop_run),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .pm_le      (pm_le),
    .pm_la      (pm_la),
    .pm_li      (pm_li),
    .pm_e       (pm_e),
    .pm_addr    (pm_addr),
    .pm_i       (pm_i),
    .run_en     (run_en),
    .jmp_valid  (jmp_valid),
    .jmp_addr   (jmp_addr),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .load_done  (load_done),
    .load_count (load_count),
    .err_ovf    (err_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int le_cnt;
  int la_bad;

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    rst = 1'b1; start_load = 0; start_run = 0; stop_run = 0;
    ld_valid = 0; ld_data = '0; ld_last = 0; run_en = 0; jmp_valid = 0; jmp_addr = '0;
    tick(); tick();
    chk("rst_pm_e", pm_e, 0);
    chk("rst_pm_addr", pm_addr, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_err_ovf", err_ovf, 0);
    rst = 1'b0;
    tick();

    // 4-word load
    start_load = 1; tick(); start_load = 0;
    chk("load_ready", ld_ready, 1);
    chk("load_cnt0", load_count, 0);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_data = 12'hA01 + 12'(i); ld_last = (i == 3);
      tick();
      chk("ld4_le", pm_le, 1);
      chk("ld4_la", pm_la, i);
      chk("ld4_li", pm_li, 32'hA01 + i);
      if (i < 3) chk("ld4_no_done", load_done, 0);
    end
    ld_valid = 0; ld_last = 0;
    chk("ld4_done", load_done, 1);
    chk("ld4_count", load_count, 4);
    chk("ld4_idle_ready", ld_ready, 0);
    tick();
    chk("ld4_le_off", pm_le, 0);
    chk("ld4_done_off", load_done, 0);

    // Run sequential fetch
    start_run = 1; run_en = 1; tick(); start_run = 0;
    chk("run_pm_e", pm_e, 1);
    chk("run_addr0", pm_addr, 0);
    chk("run_irv0", ir_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_ir", ir, 32'hA01 + i);
      chk("run_ir_pc", ir_pc, i);
      chk("run_irv", ir_valid, 1);
      chk("run_addr", pm_addr, i + 1);
    end

    // Jump from pc=3 to 2
    jmp_valid = 1; jmp_addr = 8'h02; tick(); jmp_valid = 0;
    chk("jmp_addr", pm_addr, 2);
    chk("jmp_flush", ir_valid, 0);
    tick();
    chk("jmp_ir", ir, 12'hA03);
    chk("jmp_ir_pc", ir_pc, 2);
    chk("jmp_irv", ir_valid, 1);

    // Stall for 3 cycles
    run_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", pm_addr, 3);
      chk("stall_ir", ir, 12'hA03);
      chk("stall_irv", ir_valid, 1);
    end
    run_en = 1; tick();
    chk("resume_ir", ir, 12'hA04);
    chk("resume_ir_pc", ir_pc, 3);
    chk("resume_addr", pm_addr, 4);

    // PC wrap
    jmp_valid = 1; jmp_addr = 8'hFF; tick(); jmp_valid = 0;
    chk("wrap_addr_ff", pm_addr, 8'hFF);
    tick();
    chk("wrap_addr_00", pm_addr, 0);
    chk("wrap_ir_pc", ir_pc, 8'hFF);
    chk("wrap_ir", ir, 0);

    // Leave RUN
    stop_run = 1; tick(); stop_run = 0; run_en = 0;
    chk("stop_pm_e", pm_e, 0);
    chk("stop_irv", ir_valid, 0);
    chk("stop_ir_pc_hold", ir_pc, 8'hFF);

    // 257-word overflow load
    start_load = 1; tick(); start_load = 0;
    le_cnt = 0; la_bad = 0;
    for (int i = 0; i < 257; i++) begin
      ld_valid = 1; ld_data = 12'(i) ^ 12'h5A5; ld_last = (i == 256);
      tick();
      if (pm_le) begin
        le_cnt++;
        if (pm_la !== 8'(i)) la_bad++;
      end
      if (i == 255) begin
        chk("ovf_cnt_sat", load_count, 256);
        chk("ovf_not_yet", err_ovf, 0);
      end
    end
    ld_valid = 0; ld_last = 0;
    chk("ovf_le_pulses", le_cnt, 256);
    chk("ovf_la_seq", la_bad, 0);
    chk("ovf_err", err_ovf, 1);
    chk("ovf_count", load_count, 256);
    chk("ovf_done", load_done, 1);
    chk("ovf_mem_ff", mem[8'hFF], 12'h0FF ^ 12'h5A5);

    // Async reset mid-load
    tick();
    start_load = 1; tick(); start_load = 0;
    ld_valid = 1; ld_data = 12'h123; ld_last = 0;
    tick(); tick();
    chk("mid_le", pm_le, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_le", pm_le, 0);
    chk("arst_la", pm_la, 0);
    chk("arst_li", pm_li, 0);
    chk("arst_count", load_count, 0);
    chk("arst_ready", ld_ready, 0);
    chk("arst_ir", ir, 0);
    chk("arst_ir_pc", ir_pc, 0);
    chk("arst_err", err_ovf, 0);
    ld_valid = 0;
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
